// File: rtl/de_pkg.sv
// Shared definitions for the dice roll sequencer: die ids, bounds table,
// FSM state encoding and the LFSR feedback polynomial.
package de_pkg;

   localparam int NB_W  = 4;
   localparam int DIE_W = 7;
   localparam int SUM_W = 11;

   // x^16 + x^14 + x^13 + x^11 + 1, as tap mask on a left-shifting register
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   localparam logic [2:0] D4   = 3'd0;
   localparam logic [2:0] D6   = 3'd1;
   localparam logic [2:0] D8   = 3'd2;
   localparam logic [2:0] D10  = 3'd3;
   localparam logic [2:0] D12  = 3'd4;
   localparam logic [2:0] D20  = 3'd5;
   localparam logic [2:0] D30  = 3'd6;
   localparam logic [2:0] D100 = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [DIE_W-1:0] dmin;
      logic [DIE_W-1:0] dmax;
      logic [DIE_W-1:0] mask;
   } bounds_t;

   // mask is the smallest 2^k-1 covering dmax-dmin, so rejection stays below 50%
   function automatic bounds_t die_bounds(input logic [2:0] id);
      bounds_t b;
      case (id)
         D4:      b = '{dmin: 7'd1, dmax: 7'd4,  mask: 7'd3};
         D6:      b = '{dmin: 7'd1, dmax: 7'd6,  mask: 7'd7};
         D8:      b = '{dmin: 7'd1, dmax: 7'd8,  mask: 7'd7};
         D10:     b = '{dmin: 7'd0, dmax: 7'd9,  mask: 7'd15};
         D12:     b = '{dmin: 7'd1, dmax: 7'd12, mask: 7'd15};
         D20:     b = '{dmin: 7'd1, dmax: 7'd20, mask: 7'd31};
         D30:     b = '{dmin: 7'd1, dmax: 7'd30, mask: 7'd31};
         default: b = '{dmin: 7'd0, dmax: 7'd99, mask: 7'd127};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/de_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with synchronous seed load.
// A zero seed is replaced by SEED so the register can never lock up.
module de_lfsr16
   import de_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [15:0] lfsr_state
);

   logic [15:0] lfsr_reg;
   logic        feedback;

   assign feedback = ^(lfsr_reg & LFSR_POLY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_reg <= SEED;
      end else if (load) begin
         lfsr_reg <= (seed == 16'h0000) ? SEED : seed;
      end else if (step) begin
         lfsr_reg <= {lfsr_reg[14:0], feedback};
      end
   end

   assign lfsr_state = lfsr_reg;

endmodule

// File: rtl/de_roll_sequencer.sv
// Multi-die roll sequencer: draws dice by mask-and-reject from an LFSR,
// streams each value and reports the total. Optional DE_SEED_LOAD_EN adds seed loading.
module de_roll_sequencer
   import de_pkg::*;
#(
   parameter int          MAX_NB    = 15,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DE_SEED_LOAD_EN
   input  logic             seed_load,
   input  logic [15:0]      seed,
`endif
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_id,
   input  logic [NB_W-1:0]  req_nb,
   output logic             busy,
   output logic             die_valid,
   output logic [DIE_W-1:0] die_val,
   output logic [NB_W-1:0]  die_idx,
   output logic             done,
   output logic [SUM_W-1:0] sum
);

   state_t           state_reg, state_next;
   logic [NB_W-1:0]  nb_reg;
   logic [DIE_W-1:0] dmin_reg, range_reg, mask_reg;
   logic [DIE_W-1:0] die_val_reg;
   logic [NB_W-1:0]  die_idx_reg;
   logic [SUM_W-1:0] sum_reg;

   logic [15:0]      lfsr;
   logic [8:0]       unused_lfsr_hi;
   logic             lfsr_load;
   logic [15:0]      lfsr_seed;
   bounds_t          bounds;
   logic [DIE_W-1:0] cand, draw_val;
   logic             hit, last, accept;

`ifdef DE_SEED_LOAD_EN
   assign lfsr_load = seed_load;
   assign lfsr_seed = seed;
`else
   assign lfsr_load = 1'b0;
   assign lfsr_seed = 16'h0000;
`endif

   de_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .step       (1'b1),
      .load       (lfsr_load),
      .seed       (lfsr_seed),
      .lfsr_state (lfsr)
   );

   // only the low bits feed the sampler
   assign unused_lfsr_hi = lfsr[15:7];

   assign bounds   = die_bounds(req_id);
   assign cand     = lfsr[DIE_W-1:0] & mask_reg;
   assign hit      = (cand <= range_reg);
   assign draw_val = dmin_reg + cand;
   assign last     = (die_idx_reg == nb_reg - 4'd1);
   assign accept   = (state_reg == IDLE) && req_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_valid) state_next = (req_nb == 4'd0) ? DONE : DRAW;
         DRAW:    if (hit) state_next = EMIT;
         EMIT:    state_next = last ? DONE : DRAW;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nb_reg      <= '0;
         dmin_reg    <= '0;
         range_reg   <= '0;
         mask_reg    <= '0;
         die_val_reg <= '0;
         die_idx_reg <= '0;
         sum_reg     <= '0;
      end else begin
         if (accept) begin
            nb_reg      <= (req_nb > 4'(MAX_NB)) ? 4'(MAX_NB) : req_nb;
            dmin_reg    <= bounds.dmin;
            range_reg   <= bounds.dmax - bounds.dmin;
            mask_reg    <= bounds.mask;
            die_idx_reg <= '0;
            sum_reg     <= '0;
         end
         if ((state_reg == DRAW) && hit) begin
            die_val_reg <= draw_val;
            sum_reg     <= sum_reg + {4'd0, draw_val};
         end
         if ((state_reg == EMIT) && !last) begin
            die_idx_reg <= die_idx_reg + 4'd1;
         end
      end
   end

   assign req_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign die_valid = (state_reg == EMIT);
   assign done      = (state_reg == DONE);
   assign die_val   = die_val_reg;
   assign die_idx   = die_idx_reg;
   assign sum       = sum_reg;

endmodule
